// File: rtl/io_pkg.sv
// Register map shared by the I/O port bank and its output FIFOs.
package io_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_IN_AVAIL  = 0;
  localparam int ST_OUT_FULL  = 1;
  localparam int ST_OUT_EMPTY = 2;
  localparam int ST_OVERFLOW  = 3;

endpackage

// File: rtl/io_fifo.sv
// Per-channel output FIFO: registered head, no fall-through, power-of-two depth.
module io_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop_ok)  rptr <= rptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_CH device channels: one-entry input holding register
// and an output FIFO per channel, reached through a DATA/STATUS register pair.
module io_port_bank
  import io_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int OUT_DEPTH = 4,
  parameter int ADDR_W    = $clog2(NUM_CH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [DATA_W-1:0]        io_out0
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  function automatic logic [DATA_W-1:0] pack_status(input logic avail, input logic full,
                                                    input logic empty, input logic ovf);
    logic [DATA_W-1:0] s;
    s               = '0;
    s[ST_IN_AVAIL]  = avail;
    s[ST_OUT_FULL]  = full;
    s[ST_OUT_EMPTY] = empty;
    s[ST_OVERFLOW]  = ovf;
    return s;
  endfunction

  logic [ADDR_W-1:0]              ch_idx;
  logic                           reg_sel;
  logic [NUM_CH-1:0]              ch_hit;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_word;
  logic [DATA_W-1:0]              rd_word;

  // Channel index lives above the register-select bit; out-of-range indices hit nothing.
  assign ch_idx  = addr >> 1;
  assign reg_sel = addr[0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              avail_q;
    logic              ovf_q;
    logic [DATA_W-1:0] hold_q;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign ch_hit[c]   = (ch_idx == ADDR_W'(c));
    assign push        = wr_en && ch_hit[c] && (reg_sel == REG_DATA);
    assign pop         = out_valid[c] && out_ready[c];
    assign in_ready[c] = !avail_q;
    assign out_valid[c] = (fifo_count != '0);
    assign ch_word[c]  = (reg_sel == REG_STATUS)
                         ? pack_status(avail_q, fifo_full, fifo_empty, ovf_q)
                         : hold_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        avail_q <= 1'b0;
        hold_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (in_valid[c] && !avail_q) begin
          hold_q  <= in_data[c*DATA_W +: DATA_W];
          avail_q <= 1'b1;
        end else if (rd_en && ch_hit[c] && (reg_sel == REG_DATA)) begin
          avail_q <= 1'b0;
        end
        if (push && fifo_full && !pop)
          ovf_q <= 1'b1;
        else if (wr_en && ch_hit[c] && (reg_sel == REG_STATUS) && wdata[ST_OVERFLOW])
          ovf_q <= 1'b0;
      end
    end

    io_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (OUT_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   (wdata),
      .head    (out_data[c*DATA_W +: DATA_W]),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
    );
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) rd_word = ch_word[c];
    end
  end

  // Read data registered one cycle after rd_en; STATUS reflects pre-write state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata   <= '0;
      io_out0 <= '0;
    end else begin
      if (rd_en) rdata <= rd_word;
      if (wr_en && (ch_idx == '0) && (reg_sel == REG_DATA)) io_out0 <= wdata;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed-vector bench for io_port_bank (NUM_CH=2, widened address to reach channel 2).
module tb_io_port_bank;

  localparam int DW = 16;
  localparam int NC = 2;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [AW-1:0]    addr;
  logic             wr_en;
  logic             rd_en;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]    in_valid;
  logic [NC-1:0]    in_ready;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready;
  logic [DW-1:0]    io_out0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] rd;

  io_port_bank #(
    .DATA_W    (DW),
    .NUM_CH    (NC),
    .OUT_DEPTH (4),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .io_out0   (io_out0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic proc_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    addr  = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    d     = rdata;
  endtask

  task automatic proc_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    addr      = '0;
    wr_en     = 1'b1;
    rd_en     = 1'b0;
    wdata     = 16'hBEEF;
    in_data   = 32'h1111_2222;
    in_valid  = 2'b11;
    out_ready = 2'b00;
    step();
    step();
    check("rst_in_ready", in_ready, 2'b11);
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_out_data", out_data, 32'h0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_io_out0", io_out0, 16'h0);
    reset_n  = 1'b1;
    wr_en    = 1'b0;
    in_valid = 2'b00;
    proc_read(3'd1, rd);
    check("rst_status0", rd, 16'h0004);

    // input capture and pop
    in_data[15:0] = 16'd5040;
    in_valid      = 2'b01;
    step();
    in_valid = 2'b00;
    check("cap_in_ready", in_ready, 2'b10);
    proc_read(3'd1, rd);
    check("cap_status0", rd, 16'h0005);
    proc_read(3'd0, rd);
    check("cap_data0", rd, 16'd5040);
    check("cap_in_ready_after", in_ready, 2'b11);
    proc_read(3'd0, rd);
    check("cap_data0_again", rd, 16'd5040);
    proc_read(3'd1, rd);
    check("cap_status0_after", rd, 16'h0004);

    // ch1 fill and overflow
    for (int i = 0; i < 5; i++) proc_write(3'd2, DW'(11 + i));
    proc_read(3'd3, rd);
    check("ovf_status1", rd, 16'h000A);
    check("ovf_head1", out_data[31:16], 16'd11);
    out_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain1", out_data[31:16], 32'(11 + i));
      step();
    end
    out_ready = 2'b00;
    check("ovf_valid1_empty", out_valid[1], 1'b0);
    addr  = 3'd3;
    wdata = 16'h0008;
    rd_en = 1'b1;
    wr_en = 1'b1;
    step();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("ovf_status_prewrite", rdata, 16'h000C);
    proc_read(3'd3, rd);
    check("ovf_cleared", rd, 16'h0004);

    // full push+pop on ch0 with pointer wrap
    for (int i = 1; i <= 4; i++) proc_write(3'd0, DW'(i));
    out_ready = 2'b01;
    proc_write(3'd0, 16'd5);
    out_ready = 2'b00;
    proc_read(3'd1, rd);
    check("pp_status0", rd, 16'h0002);
    out_ready = 2'b01;
    for (int i = 2; i <= 5; i++) begin
      check("pp_drain0", out_data[15:0], 32'(i));
      step();
    end
    out_ready = 2'b00;
    check("pp_valid0_empty", out_valid[0], 1'b0);

    // channel isolation, io_out0 mirror, out-of-range channel
    proc_write(3'd0, 16'd350);
    proc_write(3'd2, 16'd7);
    check("iso_io_out0", io_out0, 16'd350);
    check("iso_head1", out_data[31:16], 16'd7);
    check("iso_head0", out_data[15:0], 16'd350);
    proc_read(3'd1, rd);
    check("iso_status0", rd, 16'h0000);
    proc_read(3'd0, rd);
    check("iso_data0", rd, 16'd5040);
    step();
    check("iso_rdata_hold", rdata, 16'd5040);
    proc_read(3'd4, rd);
    check("iso_ch2_read", rd, 16'h0000);
    proc_write(3'd4, 16'd99);
    check("iso_ch2_wr_io_out0", io_out0, 16'd350);
    check("iso_ch2_wr_out", out_data, {16'd7, 16'd350});

    // simultaneous read and write of ch0 DATA
    addr  = 3'd0;
    wdata = 16'd77;
    rd_en = 1'b1;
    wr_en = 1'b1;
    step();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("rw_rdata", rdata, 16'd5040);
    check("rw_io_out0", io_out0, 16'd77);

    // reset mid-operation
    proc_write(3'd0, 16'd78);
    in_data[15:0] = 16'd1234;
    in_valid      = 2'b01;
    step();
    in_valid = 2'b00;
    proc_read(3'd1, rd);
    check("mid_status0", rd, 16'h0001);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_out_valid", out_valid, 2'b00);
    check("mid_in_ready", in_ready, 2'b11);
    check("mid_io_out0", io_out0, 16'h0);
    proc_read(3'd0, rd);
    check("mid_data0", rd, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised successor to the processor's single ioIn/ioOut pair.
- Provides NUM_CH independent memory-mapped I/O channels between the 16-bit datapath and external devices.
- Each channel has a one-entry input holding register and an OUT_DEPTH-entry output FIFO. Both device sides use valid/ready handshakes.
- Sits beside the memory unit. The datapath reaches it through a small register-mapped port with one-cycle read latency.

Parameters:
- DATA_W, 16, width of data words and registers.
- NUM_CH, 2, number of I/O channels (1..8).
- OUT_DEPTH, 4, output FIFO depth per channel (power of two, at least 2).
- ADDR_W, $clog2(NUM_CH)+1, register address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- addr  in  ADDR_W  register address; addr[0]=reg select (0=DATA, 1=STATUS), upper bits=channel.
- wr_en  in  1  processor write strobe.
- rd_en  in  1  processor read strobe.
- wdata  in  DATA_W  processor write data.
- rdata  out  DATA_W  processor read data, valid the cycle after rd_en.
- in_data  in  NUM_CH*DATA_W  device input words; channel c occupies bits [c*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  device input valid per channel.
- in_ready  out  NUM_CH  block can accept input per channel.
- out_data  out  NUM_CH*DATA_W  head of each output FIFO.
- out_valid  out  NUM_CH  output FIFO non-empty.
- out_ready  in  NUM_CH  device accepts output word.
- io_out0  out  DATA_W  last word written to channel 0 DATA; compatibility mirror of legacy ioOut.

Behaviour:
- Reset (reset_n=0 at clk edge) clears:
  - all input holding registers and in_avail flags;
  - FIFO pointers and counts;
  - overflow flags;
  - rdata=0 and io_out0=0.
- Resulting outputs: in_ready=all 1s, out_valid=0, out_data=0.
- Reset has priority over every strobe and handshake in the same cycle. Reset mid-operation discards all buffered data.
- Input path, per channel:
  - in_ready = !in_avail (registered, no combinational path from rd_en).
  - in_valid && in_ready at an edge: capture the word and set in_avail.
- Processor reads:
  - DATA read: rdata=held word on the next cycle. If in_avail=1, clear it (pop). If in_avail=0, return the held word without popping.
  - STATUS read: bit0=in_avail, bit1=out_full, bit2=out_empty, bit3=overflow, other bits 0.
  - Read of a channel index >= NUM_CH returns 0 with no side effects.
  - rdata holds its value when rd_en=0.
- Processor writes:
  - DATA write: push wdata to that channel's output FIFO.
  - Channel 0 DATA write also updates io_out0, even when the push is dropped.
  - STATUS write with wdata[3]=1 clears overflow; other bits are ignored.
  - Write to a channel index >= NUM_CH is ignored.
- rd_en and wr_en together in one cycle: both are performed. A read of STATUS returns the pre-write values.
- Output FIFO, per channel:
  - out_valid = (count != 0); out_data = head entry (0 when empty).
  - Pop on out_valid && out_ready.
  - Push when full without a simultaneous pop: word dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only; out_valid rises the next cycle (no fall-through).
  - Read/write pointers are $clog2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH. Count is $clog2(OUT_DEPTH)+1 bits, range 0..OUT_DEPTH.
  - out_full = (count==OUT_DEPTH); out_empty = (count==0).
- Latency:
  - device input to STATUS bit0 visible: 1 cycle;
  - processor write to out_valid: 1 cycle;
  - read data: 1 cycle.

Decomposition:
- Shared package io_pkg holds:
  - register offsets REG_DATA=0 and REG_STATUS=1;
  - STATUS bit positions ST_IN_AVAIL=0, ST_OUT_FULL=1, ST_OUT_EMPTY=2, ST_OVERFLOW=3.
- Sub-module io_fifo (DATA_W, DEPTH) implements one output FIFO with push/pop/full/empty/count. It is instantiated NUM_CH times in a generate loop.
- Input registers, address decode and read mux stay in io_port_bank.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=all 1s and wr_en=1 -> in_ready=all 1s, out_valid=0, rdata=0, io_out0=0; STATUS ch0 reads 0x0004 after release.
- Input capture: ch0 in_data=5040, in_valid pulse -> in_ready[0]=0; STATUS ch0=0x0005; DATA read returns 5040 next cycle; in_ready[0]=1 afterwards; second DATA read returns 5040 with in_avail=0.
- FIFO fill/overflow: out_ready=0, write 11,12,13,14,15 to ch1 DATA -> STATUS ch1=0x000A; then with out_ready=1, out_data drains 11,12,13,14 in order; overflow remains until a STATUS write of 0x0008 clears it.
- Full push+pop: ch0 full with {1,2,3,4}, write 5 in the same cycle as out_ready=1 -> no overflow, subsequent drain order 2,3,4,5; pointer wrap verified.
- Channel isolation and io_out0: write 350 to ch0 and 7 to ch1 -> io_out0=350, out_data ch1=7, ch0 FIFO unaffected; read of addr for channel 2 (NUM_CH=2) returns 0.
- Reset mid-operation: ch0 FIFO holding 3 words and in_avail=1, assert reset_n=0 one cycle -> out_valid=0, in_ready=1; next DATA read returns 0.
